// File: rtl/timer_arb_pkg.sv
// Shared definitions for the timer arbiter: FSM encoding, GAP length, default sizes.
// Latency: none (package only).
// Backpressure: none (package only).
package timer_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Cycles with timer_start low between two timer periods of one grant.
  localparam int GAP_LEN = 1;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CW      = 4;

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
// Latency: combinational, no registers.
// Backpressure: none; vld=0 when no request is pending.
//   req : request vector        ptr : search start index
//   vld : some request is set   idx : chosen requester index
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic               vld,
  output logic [IDXW-1:0]    idx
);

  always_comb begin
    int j;
    vld = 1'b0;
    idx = '0;
    j   = 0;
    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (req[j]) begin
        vld = 1'b1;
        idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one timer between NUM_REQ requesters; grants round-robin, restarts the timer per period.
// Latency: req->grant/timer_start 1 cycle from IDLE; last timer_done->done pulse 1 cycle.
// Backpressure: requesters hold req until done; dropping req[owner] in RUN/GAP cancels the grant.
//   clk, rst_n      : clock, async active-low reset
//   req, periods    : level requests, packed per-requester period counts (CW bits each)
//   grant, done     : one-hot ownership, one-cycle completion pulse to owner
//   busy            : arbiter not in IDLE
//   timer_start     : to timer start_clock      timer_done : from timer clock_done
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CW      = DEF_CW,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*CW-1:0] periods,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic                  timer_start,
  input  logic                  timer_done
);

  localparam int GAP_CW = 4;

  state_t              state;
  logic [IDXW-1:0]     ptr;
  logic [IDXW-1:0]     owner;
  logic [CW-1:0]       remaining;
  logic [GAP_CW-1:0]   gap_cnt;

  logic                pick_vld;
  logic [IDXW-1:0]     pick_idx;
  logic [CW-1:0]       pick_cnt;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDXW-1:0]     owner_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign pick_cnt  = periods[int'(pick_idx)*CW +: CW];
  assign pick_oh   = NUM_REQ'(1) << pick_idx;
  assign owner_inc = (int'(owner) == NUM_REQ - 1) ? '0 : owner + IDXW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      remaining   <= '0;
      gap_cnt     <= '0;
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      timer_start <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner     <= pick_idx;
            remaining <= pick_cnt;
            grant     <= pick_oh;
            busy      <= 1'b1;
            if (pick_cnt != '0) begin
              state       <= ST_RUN;
              timer_start <= 1'b1;
            end else begin
              state <= ST_FINISH;
            end
          end
        end

        ST_RUN: begin
          // A dropped request wins over a simultaneous timer_done.
          if (!req[owner]) begin
            state       <= ST_IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            timer_start <= 1'b0;
            ptr         <= owner_inc;
          end else if (timer_done) begin
            timer_start <= 1'b0;
            if (remaining == CW'(1)) begin
              state <= ST_FINISH;
              done  <= grant;
            end else begin
              remaining <= remaining - CW'(1);
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          // timer_start is low here so the timer drops its sticky done flag.
          if (!req[owner]) begin
            state       <= ST_IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            timer_start <= 1'b0;
            ptr         <= owner_inc;
          end else if (gap_cnt == GAP_CW'(GAP_LEN - 1)) begin
            state       <= ST_RUN;
            timer_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_CW'(1);
          end
        end

        ST_FINISH: begin
          // Coming from RUN the done pulse is already out. A zero-length grant
          // arrives with done low, so it spends one more cycle here to pulse it,
          // letting the owner see grant before done.
          if (done == '0) begin
            done <= grant;
          end else begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= owner_inc;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: vector table, directed corner sequences, random vs. model.
// Latency: n/a (testbench).
// Backpressure: requesters hold req until done unless a cancel is being exercised.
module tb_timer_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] periods;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        timer_start;
  logic        timer_done;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Timer model: done rises tlen cycles after start rises, sticky while start held.
  int          tlen = 2;
  int          tcnt;
  logic        td_model;
  logic        tmr_manual = 1'b0;
  logic        td_man     = 1'b0;

  assign timer_done = tmr_manual ? td_man : td_model;

  timer_arbiter #(
    .NUM_REQ (4),
    .CW      (4),
    .IDXW    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .periods     (periods),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .timer_start (timer_start),
    .timer_done  (timer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt     <= 0;
      td_model <= 1'b0;
    end else if (!timer_start) begin
      tcnt     <= 0;
      td_model <= 1'b0;
    end else if (tcnt >= tlen - 1) begin
      td_model <= 1'b1;
    end else begin
      tcnt <= tcnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 4'b0000;
    periods = 16'h0000;
    tick();
    tick();
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tstart", int'(timer_start), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    tick();
    while (grant == 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_wait_grant"}, int'(grant != 4'b0000), 1);
  endtask

  // One-grant vectors from reset, timer length 2 (one period = 4 cycles of grant).
  typedef struct {
    logic [3:0]  req;
    logic [15:0] per;
    logic [3:0]  exp_grant;
    int          exp_len;
  } vec_t;

  vec_t vt[6];

  // Reference model state for the random phase.
  int          m_act, m_own, m_ptr, m_age, m_len, m_cnt;
  logic [3:0]  req_q;
  logic [15:0] per_q;

  task automatic run_random(input int tl, input int ncyc);
    logic [3:0] eg, ed;
    int         ets, found;
    tlen = tl;
    do_reset();
    m_act = 0; m_own = 0; m_ptr = 0; m_age = 0; m_len = 0; m_cnt = 0;
    req_q = req;
    per_q = periods;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      // Advance the model across the edge just taken, using last cycle's inputs.
      if (m_act == 0) begin
        if (req_q != 4'b0000) begin
          found = 0;
          for (int k = 0; k < 4; k++) begin
            if (found == 0 && req_q[(m_ptr + k) % 4]) begin
              m_own = (m_ptr + k) % 4;
              found = 1;
            end
          end
          m_act = 1;
          m_age = 1;
          m_cnt = int'(per_q[m_own*4 +: 4]);
          m_len = (m_cnt == 0) ? 2 : m_cnt * (tl + 2);
        end
      end else if (m_cnt != 0 && m_age < m_len && !req_q[m_own]) begin
        m_act = 0;
        m_ptr = (m_own + 1) % 4;
      end else if (m_age == m_len) begin
        m_act = 0;
        m_ptr = (m_own + 1) % 4;
      end else begin
        m_age++;
      end
      eg  = (m_act != 0) ? (4'b0001 << m_own) : 4'b0000;
      ed  = (m_act != 0 && m_age == m_len) ? eg : 4'b0000;
      ets = (m_act != 0 && m_cnt != 0 && (m_age % (tl + 2)) != 0) ? 1 : 0;
      check("rand_grant", int'(grant), int'(eg));
      check("rand_done", int'(done), int'(ed));
      check("rand_busy", int'(busy), m_act);
      check("rand_tstart", int'(timer_start), ets);
      // Requesters react to what they see this cycle.
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (done[i]) begin
            if ($urandom_range(0, 2) == 0) periods[i*4 +: 4] = 4'($urandom_range(0, 3));
            else req[i] = 1'b0;
          end else if (grant[i]) begin
            if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            periods[i*4 +: 4] = 4'($urandom_range(0, 3));
          end
        end else if ($urandom_range(0, 5) == 0) begin
          req[i]            = 1'b1;
          periods[i*4 +: 4] = 4'($urandom_range(0, 3));
        end
      end
      req_q = req;
      per_q = periods;
    end
  endtask

  initial begin
    int len, dcnt, dcyc, rises, gaps, tdr, td3, badg, ng, idle, in_g, tsh, d1, d2;
    logic       prev_ts, prev_td;
    logic [3:0] dval;
    logic [3:0] glist[4];
    int         gapl[4];
    int         dper[4];

    rst_n   = 1'b0;
    req     = 4'b0000;
    periods = 16'h0000;

    vt[0] = '{4'b0001, 16'h0001, 4'b0001, 4};
    vt[1] = '{4'b1111, 16'h321F, 4'b0001, 60};
    vt[2] = '{4'b1000, 16'h2000, 4'b1000, 8};
    vt[3] = '{4'b0110, 16'h0000, 4'b0010, 2};
    vt[4] = '{4'b1100, 16'h0300, 4'b0100, 12};
    vt[5] = '{4'b1010, 16'h00A0, 4'b0010, 40};

    // Table-driven single grants.
    tlen = 2;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      req     = vt[v].req;
      periods = vt[v].per;
      wait_grant("vec");
      check("vec_grant", int'(grant), int'(vt[v].exp_grant));
      len = 0; dcnt = 0; dcyc = -1; dval = 4'b0000;
      while (grant != 4'b0000 && len < 300) begin
        len++;
        if (done != 4'b0000) begin
          dcnt++;
          dcyc = len;
          dval = done;
        end
        tick();
      end
      req = 4'b0000;
      check("vec_len", len, vt[v].exp_len);
      check("vec_done_cnt", dcnt, 1);
      check("vec_done_last", dcyc, len);
      check("vec_done_val", int'(dval), int'(vt[v].exp_grant));
    end

    // Single requester, 3 periods of 10 cycles.
    tlen = 10;
    do_reset();
    req     = 4'b0001;
    periods = 16'h0003;
    wait_grant("single");
    len = 0; rises = 0; gaps = 0; dcnt = 0; tdr = 0; td3 = -10; dcyc = -1; badg = 0;
    prev_ts = 1'b0; prev_td = 1'b0;
    while (grant != 4'b0000 && len < 300) begin
      len++;
      if (grant != 4'b0001) badg++;
      if (timer_start && !prev_ts) rises++;
      if (!timer_start && done == 4'b0000) gaps++;
      if (timer_done && !prev_td) begin
        tdr++;
        if (tdr == 3) td3 = len;
      end
      if (done != 4'b0000) begin
        dcnt++;
        dcyc = len;
      end
      prev_ts = timer_start;
      prev_td = timer_done;
      tick();
    end
    req = 4'b0000;
    check("single_grant_stable", badg, 0);
    check("single_len", len, 36);
    check("single_tstart_rises", rises, 3);
    check("single_gap_lows", gaps, 2);
    check("single_done_cnt", dcnt, 1);
    check("single_done_timing", dcyc, td3 + 1);
    check("single_busy_after", int'(busy), 0);

    // Contention: 0,1,3 all held, one period each.
    tlen = 2;
    do_reset();
    req     = 4'b1011;
    periods = 16'h1111;
    ng = 0; idle = 0; in_g = 0;
    for (int i = 0; i < 4; i++) begin
      glist[i] = 4'b0000;
      gapl[i]  = -1;
      dper[i]  = 0;
    end
    for (int c = 0; c < 200; c++) begin
      tick();
      if (grant != 4'b0000) begin
        if (in_g == 0 && ng < 4) begin
          glist[ng] = grant;
          gapl[ng]  = idle;
          ng++;
        end
        in_g = 1;
        if (done != 4'b0000 && ng > 0) dper[ng-1]++;
      end else begin
        if (in_g != 0) idle = 0;
        in_g = 0;
        idle++;
      end
      if (ng == 4 && in_g == 0) break;
    end
    req = 4'b0000;
    check("cont_grant0", int'(glist[0]), 1);
    check("cont_grant1", int'(glist[1]), 2);
    check("cont_grant2", int'(glist[2]), 8);
    check("cont_grant3", int'(glist[3]), 1);
    for (int i = 1; i < 4; i++) check("cont_idle_gap", gapl[i], 1);
    for (int i = 0; i < 4; i++) check("cont_done_per_grant", dper[i], 1);

    // Zero-length grant.
    do_reset();
    req     = 4'b0100;
    periods = 16'h0000;
    wait_grant("zero");
    tsh = int'(timer_start);
    check("zero_c1_grant", int'(grant), 4);
    check("zero_c1_done", int'(done), 0);
    tick();
    tsh = tsh | int'(timer_start);
    check("zero_c2_grant", int'(grant), 4);
    check("zero_c2_done", int'(done), 4);
    req = 4'b0000;
    tick();
    tsh = tsh | int'(timer_start);
    check("zero_c3_grant", int'(grant), 0);
    tick();
    tsh = tsh | int'(timer_start);
    check("zero_tstart_never", tsh, 0);

    // Cancel during GAP with a pending requester.
    tlen = 2;
    do_reset();
    req     = 4'b0110;
    periods = 16'h0140;
    wait_grant("cancel");
    check("cancel_first_grant", int'(grant), 2);
    d1 = 0; d2 = 0;
    for (int n = 0; n < 50 && !(grant != 4'b0000 && !timer_start); n++) begin
      d1 = d1 | int'(done[1]);
      tick();
    end
    check("cancel_in_gap", int'(grant != 4'b0000 && !timer_start), 1);
    req = 4'b0100;
    tick();
    d1 = d1 | int'(done[1]);
    check("cancel_grant_off", int'(grant), 0);
    check("cancel_tstart_off", int'(timer_start), 0);
    tick();
    check("cancel_next_grant", int'(grant), 4);
    for (int n = 0; n < 50 && grant != 4'b0000; n++) begin
      d1 = d1 | int'(done[1]);
      if (done[2]) begin
        d2++;
        req = 4'b0000;
      end
      tick();
    end
    check("cancel_no_done1", d1, 0);
    check("cancel_done2_cnt", d2, 1);

    // Cancel in the same cycle as the last timer_done.
    do_reset();
    tmr_manual = 1'b1;
    td_man     = 1'b0;
    req        = 4'b0001;
    periods    = 16'h0001;
    wait_grant("simul");
    tick();
    tick();
    check("simul_still_run", int'(grant), 1);
    td_man = 1'b1;
    req    = 4'b0000;
    tick();
    check("simul_grant", int'(grant), 0);
    check("simul_done", int'(done), 0);
    check("simul_busy", int'(busy), 0);
    td_man = 1'b0;
    tick();
    check("simul_done_later", int'(done), 0);
    tmr_manual = 1'b0;

    // Asynchronous reset mid-RUN, then ptr restored.
    tlen = 10;
    do_reset();
    req     = 4'b0001;
    periods = 16'h0005;
    wait_grant("async");
    tick();
    tick();
    check("async_pre_busy", int'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_grant", int'(grant), 0);
    check("async_tstart", int'(timer_start), 0);
    check("async_busy", int'(busy), 0);
    req     = 4'b0010;
    periods = 16'h0020;
    tick();
    rst_n = 1'b1;
    wait_grant("async_after");
    check("async_after_grant", int'(grant), 2);
    len = 0; dcnt = 0;
    while (grant != 4'b0000 && len < 300) begin
      len++;
      if (done != 4'b0000) begin
        dcnt++;
        req = 4'b0000;
      end
      tick();
    end
    check("async_after_len", len, 24);
    check("async_after_done", dcnt, 1);

    // Random traffic against the reference model.
    run_random(1, 1500);
    run_random(3, 1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
